// File: rtl/shift_pipe_pkg.sv
// Shared op codes and decode helpers for the pipelined barrel shifter.
package shift_pipe_pkg;

    localparam int SH_OP_W = 3;

    typedef enum logic [SH_OP_W-1:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } sh_op_e;

    function automatic logic sh_is_eq(input logic [SH_OP_W-1:0] op, input sh_op_e code);
        return op == code;
    endfunction

    // Right-going ops are executed as reverse -> left shift -> reverse.
    function automatic logic sh_is_right(input logic [SH_OP_W-1:0] op);
        return sh_is_eq(op, SH_SRL) || sh_is_eq(op, SH_SRA) || sh_is_eq(op, SH_ROR);
    endfunction

    function automatic logic sh_is_rot(input logic [SH_OP_W-1:0] op);
        return sh_is_eq(op, SH_ROL) || sh_is_eq(op, SH_ROR);
    endfunction

    function automatic logic sh_is_rsvd(input logic [SH_OP_W-1:0] op);
        return op > SH_ROR;
    endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// One combinational 2^K left-shift level; vacated bits come from the wrapped
// top bits when rotating, otherwise from the fill bit.
module shift_level
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             rot_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int SH = 1 << K;

    logic [SH-1:0] low;

    always_comb begin
        low    = rot_i ? data_i[WIDTH-1 -: SH] : {SH{fill_i}};
        data_o = en_i ? {data_i[WIDTH-SH-1:0], low} : data_i;
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined log-structured barrel shifter (SLL/SRL/SRA/ROL/ROR) with
// valid/ready handshake, collapsing bubbles and a pass-through tag.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [AMT_W-1:0]   in_amt,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int L   = STAGES - 1;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    logic [WIDTH-1:0] data_q [STAGES];
    logic [WIDTH-1:0] data_d [STAGES];
    logic [SHW-1:0]   amt_q  [STAGES];
    logic [SHW-1:0]   amt_d  [STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];
    logic [TAG_W-1:0] tag_d  [STAGES];
    logic [STAGES-1:0] vld_q, vld_d, rev_q, rev_d, rot_q, rot_d;
    logic [STAGES-1:0] fill_q, fill_d, oor_q, oor_d, err_q, err_d;

    // Per-stage inputs: stage 0 sees decoded request, stage s sees register s-1.
    logic [WIDTH-1:0] src_data [STAGES];
    logic [SHW-1:0]   src_amt  [STAGES];
    logic [TAG_W-1:0] src_tag  [STAGES];
    logic [STAGES-1:0] src_vld, src_rev, src_rot, src_fill, src_oor, src_err;

    logic [WIDTH-1:0] lvl_out [SHW];
    logic [WIDTH-1:0] stg_out [STAGES];
    logic [WIDTH-1:0] fin;
    logic [STAGES:0]  adv;

    always_comb begin
        adv[STAGES] = out_ready;
        for (int s = STAGES-1; s >= 0; s--) adv[s] = !vld_q[s] || adv[s+1];
    end

    assign in_ready = adv[0] && !flush;

    always_comb begin
        src_vld[0]  = in_valid && in_ready;
        src_rev[0]  = sh_is_right(in_op);
        src_rot[0]  = sh_is_rot(in_op);
        src_err[0]  = sh_is_rsvd(in_op);
        src_fill[0] = sh_is_eq(in_op, SH_SRA) && in_data[WIDTH-1];
        src_oor[0]  = (|(in_amt >> SHW)) && !sh_is_rot(in_op);
        src_amt[0]  = in_amt[SHW-1:0];
        src_tag[0]  = in_tag;
        src_data[0] = sh_is_right(in_op) ? bit_rev(in_data) : in_data;
        for (int s = 1; s < STAGES; s++) begin
            src_vld[s]  = vld_q[s-1];
            src_rev[s]  = rev_q[s-1];
            src_rot[s]  = rot_q[s-1];
            src_err[s]  = err_q[s-1];
            src_fill[s] = fill_q[s-1];
            src_oor[s]  = oor_q[s-1];
            src_amt[s]  = amt_q[s-1];
            src_tag[s]  = tag_q[s-1];
            src_data[s] = data_q[s-1];
        end
    end

    // Level k lives in stage floor(k*STAGES/SHW); a register follows each stage's last level.
    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int LS   = (k * STAGES) / SHW;
        localparam bit FRST = (k == 0) || (((k - 1) * STAGES) / SHW != LS);
        localparam bit LST  = (k == SHW - 1) || (((k + 1) * STAGES) / SHW != LS);

        logic [WIDTH-1:0] lin;

        if (FRST) begin : g_first
            assign lin = src_data[LS];
        end else begin : g_chain
            assign lin = lvl_out[k-1];
        end

        shift_level #(.WIDTH(WIDTH), .K(k)) u_level (
            .data_i (lin),
            .en_i   (src_amt[LS][k]),
            .rot_i  (src_rot[LS]),
            .fill_i (src_fill[LS]),
            .data_o (lvl_out[k])
        );

        if (LST) begin : g_last
            assign stg_out[LS] = lvl_out[k];
        end
    end

    always_comb begin
        fin = src_rev[L] ? bit_rev(stg_out[L]) : stg_out[L];
        if (src_oor[L]) fin = {WIDTH{src_fill[L]}};
        if (src_err[L]) fin = '0;
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            vld_d[s]  = vld_q[s];
            rev_d[s]  = rev_q[s];
            rot_d[s]  = rot_q[s];
            fill_d[s] = fill_q[s];
            oor_d[s]  = oor_q[s];
            err_d[s]  = err_q[s];
            amt_d[s]  = amt_q[s];
            tag_d[s]  = tag_q[s];
            data_d[s] = data_q[s];
            if (adv[s]) begin
                vld_d[s] = src_vld[s];
                if (src_vld[s]) begin
                    rev_d[s]  = src_rev[s];
                    rot_d[s]  = src_rot[s];
                    fill_d[s] = src_fill[s];
                    oor_d[s]  = src_oor[s];
                    err_d[s]  = src_err[s];
                    amt_d[s]  = src_amt[s];
                    tag_d[s]  = src_tag[s];
                    data_d[s] = (s == L) ? fin : stg_out[s];
                end
            end
            if (flush) vld_d[s] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            rev_q  <= '0;
            rot_q  <= '0;
            fill_q <= '0;
            oor_q  <= '0;
            err_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                amt_q[s]  <= '0;
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            rev_q  <= rev_d;
            rot_q  <= rot_d;
            fill_q <= fill_d;
            oor_q  <= oor_d;
            err_q  <= err_d;
            for (int s = 0; s < STAGES; s++) begin
                amt_q[s]  <= amt_d[s];
                tag_q[s]  <= tag_d[s];
                data_q[s] <= data_d[s];
            end
        end
    end

    assign out_valid = vld_q[L];
    assign out_data  = data_q[L];
    assign out_tag   = tag_q[L];
    assign out_err   = err_q[L];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed-vector bench for shift_pipe at WIDTH=64, STAGES=2.
module tb_shift_pipe;

    localparam int WIDTH  = 64;
    localparam int AMT_W  = 8;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [7:0] amt,
                                            input logic [63:0] d);
        int m;
        m = int'(amt) % 64;
        case (op)
            3'd0: return (amt >= 8'd64) ? 64'd0 : d << amt;
            3'd1: return (amt >= 8'd64) ? 64'd0 : d >> amt;
            3'd2: return (amt >= 8'd64) ? {64{d[63]}} : 64'($signed(d) >>> amt);
            3'd3: return (m == 0) ? d : ((d << m) | (d >> (64 - m)));
            3'd4: return (m == 0) ? d : ((d >> m) | (d << (64 - m)));
            default: return 64'd0;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  amt;
        logic [63:0] data;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    vec_t vt[16];

    logic [63:0] q_data[$];
    logic [3:0]  q_tag[$];
    logic        q_err[$];

    initial begin
        int sent;
        int got;
        logic stall_prev;
        logic [63:0] held_d;
        logic [3:0]  held_t;
        logic [63:0] e_d;
        logic [3:0]  e_t;
        logic        e_e;

        vt[0]  = '{3'd0, 8'd63,  64'h1,                     64'h8000_0000_0000_0000, 1'b0};
        vt[1]  = '{3'd0, 8'd64,  64'h1,                     64'h0,                   1'b0};
        vt[2]  = '{3'd0, 8'd0,   64'h1,                     64'h1,                   1'b0};
        vt[3]  = '{3'd2, 8'd4,   64'h8000_0000_0000_0000,   64'hF800_0000_0000_0000, 1'b0};
        vt[4]  = '{3'd2, 8'd200, 64'h8000_0000_0000_0000,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[5]  = '{3'd1, 8'd4,   64'h8000_0000_0000_0000,   64'h0800_0000_0000_0000, 1'b0};
        vt[6]  = '{3'd3, 8'd65,  64'h8000_0000_0000_0001,   64'h3,                   1'b0};
        vt[7]  = '{3'd4, 8'd1,   64'h1,                     64'h8000_0000_0000_0000, 1'b0};
        vt[8]  = '{3'd5, 8'd3,   64'hFFFF_FFFF_FFFF_FFFF,   64'h0,                   1'b1};
        vt[9]  = '{3'd2, 8'd64,  64'h7000_0000_0000_0000,   64'h0,                   1'b0};
        vt[10] = '{3'd4, 8'd4,   64'h1234_5678_9ABC_DEF0,   64'h0123_4567_89AB_CDEF, 1'b0};
        vt[11] = '{3'd1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF,   64'h0,                   1'b0};
        vt[12] = '{3'd3, 8'd0,   64'h1234_5678_9ABC_DEF0,   64'h1234_5678_9ABC_DEF0, 1'b0};
        vt[13] = '{3'd2, 8'd63,  64'h8000_0000_0000_0000,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[14] = '{3'd7, 8'd1,   64'h1,                     64'h0,                   1'b1};
        vt[15] = '{3'd0, 8'd8,   64'h00FF,                  64'hFF00,                1'b0};

        #12;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data",  out_data,       64'd0);
        chk("rst out_tag",   64'(out_tag),   64'd0);
        chk("rst out_err",   64'(out_err),   64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_op     = vt[i].op;
            in_amt    = vt[i].amt;
            in_data   = vt[i].data;
            in_tag    = 4'(i);
            out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d early valid", i), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d data", i),  out_data,       vt[i].exp);
            chk($sformatf("v%0d tag", i),   64'(out_tag),   64'(i));
            chk($sformatf("v%0d err", i),   64'(out_err),   64'(vt[i].err));
        end
        @(posedge clk); #1;

        // Back-to-back stream with random backpressure.
        sent = 0;
        got = 0;
        stall_prev = 1'b0;
        held_d = '0;
        held_t = '0;
        for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
            if (stall_prev) begin
                chk("stall valid", 64'(out_valid), 64'd1);
                chk("stall data",  out_data,       held_d);
                chk("stall tag",   64'(out_tag),   64'(held_t));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 16) begin
                in_valid = 1'b1;
                in_op    = 3'($urandom_range(0, 5));
                in_amt   = 8'($urandom_range(0, 255));
                in_data  = {$urandom(), $urandom()};
                in_tag   = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                q_data.push_back(ref_res(in_op, in_amt, in_data));
                q_tag.push_back(in_tag);
                q_err.push_back(in_op > 3'd4);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    chk("stream spurious out", 64'd1, 64'd0);
                end else begin
                    e_d = q_data.pop_front();
                    e_t = q_tag.pop_front();
                    e_e = q_err.pop_front();
                    chk($sformatf("stream%0d data", got), out_data,     e_d);
                    chk($sformatf("stream%0d tag", got),  64'(out_tag), 64'(e_t));
                    chk($sformatf("stream%0d err", got),  64'(out_err), 64'(e_e));
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream count", 64'(got), 64'd16);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Flush with two ops in flight and a request offered alongside.
        in_valid = 1'b1; in_op = 3'd0; in_amt = 8'd1; in_data = 64'h1; in_tag = 4'hA;
        @(posedge clk); #1;
        in_tag = 4'hB;
        @(posedge clk); #1;
        chk("pre-flush valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        in_tag = 4'hC;
        #1;
        chk("flush in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush valid +1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush valid +2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush valid +3", 64'(out_valid), 64'd0);

        // Asynchronous reset while a result is held at the output.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd3; in_amt = 8'd5; in_data = 64'hDEAD_BEEF; in_tag = 4'h5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("held valid", 64'(out_valid), 64'd1);
        chk("held data",  out_data,       64'h1B_D5B7_DDE0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 64'(out_valid), 64'd0);
        chk("async rst data",  out_data,       64'd0);
        chk("async rst tag",   64'(out_tag),   64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst valid", 64'(out_valid), 64'd0);
        chk("post rst in_ready", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
